// File: rtl/led_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_sched_pkg
//  Purpose  : Shared types and constants for the LED latch scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package led_sched_pkg;

  // Width of the encoder slice index (covers up to 512 slices).
  localparam int SLICE_W = 9;

  // Bit length of one shifter transfer (grayscale or control frame).
  localparam int LATCH_SIZE = 769;

  // Latch-select values driven on sh_sel.
  localparam logic SEL_CTRL = 1'b1;
  localparam logic SEL_GS   = 1'b0;

  // Scheduler states; the encoding is exported on state_dbg.
  typedef enum logic [2:0] {
    CTRL_LOAD = 3'd0,
    CTRL_WAIT = 3'd1,
    ARMED     = 3'd2,
    FETCH     = 3'd3,
    GS_LOAD   = 3'd4,
    GS_WAIT   = 3'd5
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/led_latch_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_latch_scheduler_if
//  Purpose  : Encoder, fetch and shifter handshake bundle of the scheduler.
//             master = scheduler view, slave = surrounding system view.
//  Revision : 1.0 - initial release
// ============================================================================
interface led_latch_scheduler_if;
  import led_sched_pkg::*;

  logic               slice_tick;
  logic               home;
  logic               ctrl_dirty;
  logic               rd_req;
  logic               rd_ack;
  logic [SLICE_W-1:0] fetch_idx;
  logic               sh_start;
  logic               sh_sel;
  logic               sh_busy;
  logic               sh_done;
  logic [15:0]        overrun_cnt;
  logic               fault;
  logic [2:0]         state_dbg;

  modport master (
    input  slice_tick, home, ctrl_dirty, rd_ack, sh_busy, sh_done,
    output rd_req, fetch_idx, sh_start, sh_sel, overrun_cnt, fault, state_dbg
  );

  modport slave (
    output slice_tick, home, ctrl_dirty, rd_ack, sh_busy, sh_done,
    input  rd_req, fetch_idx, sh_start, sh_sel, overrun_cnt, fault, state_dbg
  );

endinterface
`default_nettype wire

// File: rtl/led_slice_counter.sv
`default_nettype none
// ============================================================================
//  Module   : led_slice_counter
//  Purpose  : Encoder slice position. Advances on every slice_tick, wraps at
//             SLICES-1, and is forced to 0 by home (home beats a tick).
//             Exposes the post-update position so a tick can be captured in
//             the same cycle it arrives.
//  Revision : 1.0 - initial release
// ============================================================================
module led_slice_counter
  import led_sched_pkg::*;
#(
  parameter int SLICES = 360
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               slice_tick,
  input  logic               home,
  output logic [SLICE_W-1:0] pos_next
);

  logic [SLICE_W-1:0] pos_q;
  logic [SLICE_W-1:0] pos_d;

  // Next position: home first, then wrap-around increment on a tick.
  always_comb begin
    pos_d = pos_q;
    if (home) begin
      pos_d = '0;
    end else if (slice_tick) begin
      if (pos_q == SLICE_W'(SLICES - 1)) begin
        pos_d = '0;
      end else begin
        pos_d = pos_q + SLICE_W'(1);
      end
    end
  end

  // Position register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_next = pos_d;

endmodule
`default_nettype wire

// File: rtl/led_latch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : led_latch_scheduler
//  Purpose  : Schedules control-latch and grayscale-latch writes to the 769-bit
//             LED shifter, one grayscale frame per encoder slice, with a
//             periodic/dirty-driven control rewrite and overrun accounting.
//  Options  : LED_SCHED_WATCHDOG_EN - adds a shifter completion watchdog that
//             raises a sticky fault and forces a control rewrite on timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module led_latch_scheduler
  import led_sched_pkg::*;
#(
  parameter int SLICES       = 360,
  parameter int CTRL_REFRESH = 64,
  parameter int WDOG_CYCLES  = 2048
) (
  input  logic                  CLK_10M,
  input  logic                  RESET,
  led_latch_scheduler_if.master bus
);

  localparam int GS_W = $clog2(CTRL_REFRESH + 1);

  // Reject configurations the fixed-width slice index cannot represent.
  if (SLICES < 1 || SLICES > (1 << SLICE_W) || CTRL_REFRESH < 1 || WDOG_CYCLES < 1)
  begin : g_param_check
    $error("led_latch_scheduler: illegal parameter set");
  end

  logic [SLICE_W-1:0] pos_next;

  led_slice_counter #(
    .SLICES (SLICES)
  ) u_slice_counter (
    .clk        (CLK_10M),
    .rst        (RESET),
    .slice_tick (bus.slice_tick),
    .home       (bus.home),
    .pos_next   (pos_next)
  );

  sched_state_e       state_q, state_d;
  logic               rd_req_q, rd_req_d;
  logic [SLICE_W-1:0] fetch_idx_q, fetch_idx_d;
  logic               sh_start_q, sh_start_d;
  logic               sh_sel_q, sh_sel_d;
  logic               ctrl_pend_q, ctrl_pend_d;
  logic [GS_W-1:0]    gs_cnt_q, gs_cnt_d;
  logic [15:0]        overrun_q, overrun_d;

`ifdef LED_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               fault_q, fault_d;
`endif

  // Scheduler next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rd_req_d    = rd_req_q;
    fetch_idx_d = fetch_idx_q;
    sh_start_d  = 1'b0;
    sh_sel_d    = sh_sel_q;
    ctrl_pend_d = ctrl_pend_q | bus.ctrl_dirty;
    gs_cnt_d    = gs_cnt_q;
    overrun_d   = overrun_q;

    // Ticks outside ARMED are lost; count them (saturating).
    if (bus.slice_tick && state_q != ARMED && overrun_q != 16'hFFFF) begin
      overrun_d = overrun_q + 16'd1;
    end

    case (state_q)
      CTRL_LOAD: begin
        if (!bus.sh_busy) begin
          sh_start_d = 1'b1;
          sh_sel_d   = SEL_CTRL;
          state_d    = CTRL_WAIT;
        end
      end
      CTRL_WAIT: begin
        if (bus.sh_done) begin
          // A dirty pulse landing on this completion is kept for the next round.
          ctrl_pend_d = bus.ctrl_dirty;
          gs_cnt_d    = '0;
          state_d     = ARMED;
        end
      end
      ARMED: begin
        if (bus.slice_tick) begin
          if (ctrl_pend_q || bus.ctrl_dirty || gs_cnt_q == GS_W'(CTRL_REFRESH)) begin
            state_d = CTRL_LOAD;
          end else begin
            fetch_idx_d = pos_next;
            rd_req_d    = 1'b1;
            state_d     = FETCH;
          end
        end
      end
      FETCH: begin
        if (rd_req_q && bus.rd_ack) begin
          rd_req_d = 1'b0;
          state_d  = GS_LOAD;
        end
      end
      GS_LOAD: begin
        if (!bus.sh_busy) begin
          sh_start_d = 1'b1;
          sh_sel_d   = SEL_GS;
          state_d    = GS_WAIT;
        end
      end
      GS_WAIT: begin
        if (bus.sh_done) begin
          if (gs_cnt_q != GS_W'(CTRL_REFRESH)) begin
            gs_cnt_d = gs_cnt_q + GS_W'(1);
          end
          state_d = ARMED;
        end
      end
      default: begin
        state_d = CTRL_LOAD;
      end
    endcase

`ifdef LED_SCHED_WATCHDOG_EN
    wdog_d  = '0;
    fault_d = fault_q;
    if ((state_q == CTRL_WAIT || state_q == GS_WAIT) && !bus.sh_done) begin
      if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
        fault_d     = 1'b1;
        ctrl_pend_d = 1'b1;
        state_d     = CTRL_LOAD;
      end else begin
        wdog_d = wdog_q + WD_W'(1);
      end
    end
`endif
  end

  // State and output registers; reset restarts with a control write.
  always_ff @(posedge CLK_10M or posedge RESET) begin
    if (RESET) begin
      state_q     <= CTRL_LOAD;
      rd_req_q    <= 1'b0;
      fetch_idx_q <= '0;
      sh_start_q  <= 1'b0;
      sh_sel_q    <= 1'b0;
      ctrl_pend_q <= 1'b1;
      gs_cnt_q    <= '0;
      overrun_q   <= '0;
`ifdef LED_SCHED_WATCHDOG_EN
      wdog_q      <= '0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rd_req_q    <= rd_req_d;
      fetch_idx_q <= fetch_idx_d;
      sh_start_q  <= sh_start_d;
      sh_sel_q    <= sh_sel_d;
      ctrl_pend_q <= ctrl_pend_d;
      gs_cnt_q    <= gs_cnt_d;
      overrun_q   <= overrun_d;
`ifdef LED_SCHED_WATCHDOG_EN
      wdog_q      <= wdog_d;
      fault_q     <= fault_d;
`endif
    end
  end

  assign bus.rd_req      = rd_req_q;
  assign bus.fetch_idx   = fetch_idx_q;
  assign bus.sh_start    = sh_start_q;
  assign bus.sh_sel      = sh_sel_q;
  assign bus.overrun_cnt = overrun_q;
  assign bus.state_dbg   = state_q;
`ifdef LED_SCHED_WATCHDOG_EN
  assign bus.fault       = fault_q;
`else
  assign bus.fault       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_latch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_latch_scheduler
//  Purpose  : Directed self-checking bench for led_latch_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_latch_scheduler;
  import led_sched_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  led_latch_scheduler_if bus_if ();

  led_latch_scheduler #(
    .SLICES       (360),
    .CTRL_REFRESH (64),
    .WDOG_CYCLES  (2048)
  ) dut (
    .CLK_10M (clk),
    .RESET   (rst),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs driven 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    bus_if.sh_done = 1'b1;
    step();
    bus_if.sh_done = 1'b0;
  endtask

  // From ARMED: tick (optionally with home), ack the fetch, land in GS_WAIT.
  task automatic run_to_gs_wait(input logic with_home);
    bus_if.slice_tick = 1'b1;
    bus_if.home       = with_home;
    step();
    bus_if.slice_tick = 1'b0;
    bus_if.home       = 1'b0;
    bus_if.rd_ack     = 1'b1;
    step();
    bus_if.rd_ack     = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (bus_if.state_dbg !== 3'(CTRL_LOAD)) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", bus_if.state_dbg, CTRL_LOAD); end
    checks++; if ({bus_if.rd_req, bus_if.sh_start, bus_if.sh_sel, bus_if.fault} !== 4'b0000) begin failures++; $display("FAIL reset_outputs got=%b exp=0000", {bus_if.rd_req, bus_if.sh_start, bus_if.sh_sel, bus_if.fault}); end
    checks++; if (bus_if.overrun_cnt !== 16'd0 || bus_if.fetch_idx !== 9'd0) begin failures++; $display("FAIL reset_counters got ovr=%0d idx=%0d exp 0/0", bus_if.overrun_cnt, bus_if.fetch_idx); end
    rst = 1'b0;
    step();
    checks++; if (bus_if.sh_start !== 1'b1 || bus_if.sh_sel !== 1'b1) begin failures++; $display("FAIL first_ctrl_start got start=%b sel=%b exp 1/1", bus_if.sh_start, bus_if.sh_sel); end
    step();
    checks++; if (bus_if.sh_start !== 1'b0 || bus_if.state_dbg !== 3'(CTRL_WAIT)) begin failures++; $display("FAIL ctrl_wait got start=%b state=%0d exp 0/%0d", bus_if.sh_start, bus_if.state_dbg, CTRL_WAIT); end
    pulse_done();
    checks++; if (bus_if.state_dbg !== 3'(ARMED)) begin failures++; $display("FAIL armed_after_ctrl got=%0d exp=%0d", bus_if.state_dbg, ARMED); end
  endtask

  task automatic test_fetch();
    bus_if.slice_tick = 1'b1;
    step();
    bus_if.slice_tick = 1'b0;
    checks++; if (bus_if.state_dbg !== 3'(FETCH) || bus_if.rd_req !== 1'b1 || bus_if.fetch_idx !== 9'd1) begin failures++; $display("FAIL fetch_entry got state=%0d req=%b idx=%0d exp %0d/1/1", bus_if.state_dbg, bus_if.rd_req, bus_if.fetch_idx, FETCH); end
    bus_if.rd_ack = 1'b1;
    step();
    bus_if.rd_ack = 1'b0;
    checks++; if (bus_if.state_dbg !== 3'(GS_LOAD) || bus_if.rd_req !== 1'b0 || bus_if.sh_start !== 1'b0) begin failures++; $display("FAIL gs_load got state=%0d req=%b start=%b exp %0d/0/0", bus_if.state_dbg, bus_if.rd_req, bus_if.sh_start, GS_LOAD); end
    step();
    checks++; if (bus_if.sh_start !== 1'b1 || bus_if.sh_sel !== 1'b0 || bus_if.state_dbg !== 3'(GS_WAIT)) begin failures++; $display("FAIL gs_start_latency got start=%b sel=%b state=%0d exp 1/0/%0d", bus_if.sh_start, bus_if.sh_sel, bus_if.state_dbg, GS_WAIT); end
    pulse_done();
    checks++; if (bus_if.state_dbg !== 3'(ARMED)) begin failures++; $display("FAIL gs_done_armed got=%0d exp=%0d", bus_if.state_dbg, ARMED); end
  endtask

  task automatic test_refresh();
    for (int i = 0; i < 63; i++) begin
      run_to_gs_wait(1'b0);
      pulse_done();
    end
    bus_if.slice_tick = 1'b1;
    step();
    bus_if.slice_tick = 1'b0;
    checks++; if (bus_if.state_dbg !== 3'(CTRL_LOAD) || bus_if.rd_req !== 1'b0) begin failures++; $display("FAIL refresh_ctrl_load got state=%0d req=%b exp %0d/0", bus_if.state_dbg, bus_if.rd_req, CTRL_LOAD); end
    step();
    checks++; if (bus_if.sh_start !== 1'b1 || bus_if.sh_sel !== 1'b1) begin failures++; $display("FAIL refresh_ctrl_start got start=%b sel=%b exp 1/1", bus_if.sh_start, bus_if.sh_sel); end
    pulse_done();
    run_to_gs_wait(1'b0);
    checks++; if (bus_if.state_dbg !== 3'(GS_WAIT) || bus_if.fetch_idx !== 9'd66) begin failures++; $display("FAIL refresh_restart got state=%0d idx=%0d exp %0d/66", bus_if.state_dbg, bus_if.fetch_idx, GS_WAIT); end
    pulse_done();
  endtask

  task automatic test_overrun();
    run_to_gs_wait(1'b0);
    bus_if.slice_tick = 1'b1;
    repeat (3) step();
    bus_if.slice_tick = 1'b0;
    checks++; if (bus_if.overrun_cnt !== 16'd3 || bus_if.state_dbg !== 3'(GS_WAIT)) begin failures++; $display("FAIL overrun_3 got cnt=%0d state=%0d exp 3/%0d", bus_if.overrun_cnt, bus_if.state_dbg, GS_WAIT); end
    pulse_done();
    run_to_gs_wait(1'b0);
    checks++; if (bus_if.fetch_idx !== 9'd71) begin failures++; $display("FAIL overrun_pos got=%0d exp=71", bus_if.fetch_idx); end
    pulse_done();
    run_to_gs_wait(1'b0);
    bus_if.slice_tick = 1'b1;
    repeat (287) step();
    bus_if.slice_tick = 1'b0;
    pulse_done();
    checks++; if (bus_if.overrun_cnt !== 16'd290) begin failures++; $display("FAIL overrun_290 got=%0d exp=290", bus_if.overrun_cnt); end
    run_to_gs_wait(1'b0);
    checks++; if (bus_if.fetch_idx !== 9'd0) begin failures++; $display("FAIL wrap_359 got=%0d exp=0", bus_if.fetch_idx); end
    pulse_done();
    run_to_gs_wait(1'b1);
    checks++; if (bus_if.fetch_idx !== 9'd0) begin failures++; $display("FAIL home_beats_tick got=%0d exp=0", bus_if.fetch_idx); end
    pulse_done();
  endtask

  task automatic test_dirty();
    bus_if.ctrl_dirty = 1'b1;
    step();
    bus_if.ctrl_dirty = 1'b0;
    bus_if.slice_tick = 1'b1;
    step();
    bus_if.slice_tick = 1'b0;
    checks++; if (bus_if.state_dbg !== 3'(CTRL_LOAD)) begin failures++; $display("FAIL dirty_ctrl_load got=%0d exp=%0d", bus_if.state_dbg, CTRL_LOAD); end
    step();
    bus_if.sh_done    = 1'b1;
    bus_if.ctrl_dirty = 1'b1;
    step();
    bus_if.sh_done    = 1'b0;
    bus_if.ctrl_dirty = 1'b0;
    bus_if.slice_tick = 1'b1;
    step();
    bus_if.slice_tick = 1'b0;
    checks++; if (bus_if.state_dbg !== 3'(CTRL_LOAD)) begin failures++; $display("FAIL dirty_on_done_kept got=%0d exp=%0d", bus_if.state_dbg, CTRL_LOAD); end
    step();
    pulse_done();
    run_to_gs_wait(1'b0);
    checks++; if (bus_if.state_dbg !== 3'(GS_WAIT) || bus_if.fetch_idx !== 9'd3) begin failures++; $display("FAIL dirty_cleared got state=%0d idx=%0d exp %0d/3", bus_if.state_dbg, bus_if.fetch_idx, GS_WAIT); end
    pulse_done();
  endtask

  task automatic test_watchdog();
    run_to_gs_wait(1'b0);
    checks++; if (bus_if.fetch_idx !== 9'd4) begin failures++; $display("FAIL wdog_fetch_idx got=%0d exp=4", bus_if.fetch_idx); end
`ifdef LED_SCHED_WATCHDOG_EN
    repeat (2047) step();
    checks++; if (bus_if.state_dbg !== 3'(GS_WAIT) || bus_if.fault !== 1'b0) begin failures++; $display("FAIL wdog_early got state=%0d fault=%b exp %0d/0", bus_if.state_dbg, bus_if.fault, GS_WAIT); end
    step();
    checks++; if (bus_if.state_dbg !== 3'(CTRL_LOAD) || bus_if.fault !== 1'b1) begin failures++; $display("FAIL wdog_expire got state=%0d fault=%b exp %0d/1", bus_if.state_dbg, bus_if.fault, CTRL_LOAD); end
    step();
    checks++; if (bus_if.sh_start !== 1'b1 || bus_if.sh_sel !== 1'b1) begin failures++; $display("FAIL wdog_ctrl_start got start=%b sel=%b exp 1/1", bus_if.sh_start, bus_if.sh_sel); end
    pulse_done();
    checks++; if (bus_if.state_dbg !== 3'(ARMED) || bus_if.fault !== 1'b1) begin failures++; $display("FAIL wdog_sticky got state=%0d fault=%b exp %0d/1", bus_if.state_dbg, bus_if.fault, ARMED); end
`else
    repeat (10000) step();
    checks++; if (bus_if.state_dbg !== 3'(GS_WAIT) || bus_if.fault !== 1'b0) begin failures++; $display("FAIL no_wdog_wait got state=%0d fault=%b exp %0d/0", bus_if.state_dbg, bus_if.fault, GS_WAIT); end
`endif
  endtask

  task automatic test_reset_mid();
    bus_if.sh_busy = 1'b1;
    #20;
    rst = 1'b1;
    #2;
    checks++; if (bus_if.state_dbg !== 3'(CTRL_LOAD) || bus_if.overrun_cnt !== 16'd0 || bus_if.fault !== 1'b0 || bus_if.sh_sel !== 1'b0) begin failures++; $display("FAIL async_reset got state=%0d ovr=%0d fault=%b sel=%b exp %0d/0/0/0", bus_if.state_dbg, bus_if.overrun_cnt, bus_if.fault, bus_if.sh_sel, CTRL_LOAD); end
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    checks++; if (bus_if.state_dbg !== 3'(CTRL_LOAD) || bus_if.sh_start !== 1'b0) begin failures++; $display("FAIL busy_hold got state=%0d start=%b exp %0d/0", bus_if.state_dbg, bus_if.sh_start, CTRL_LOAD); end
    bus_if.sh_busy = 1'b0;
    step();
    checks++; if (bus_if.sh_start !== 1'b1 || bus_if.sh_sel !== 1'b1) begin failures++; $display("FAIL post_reset_ctrl got start=%b sel=%b exp 1/1", bus_if.sh_start, bus_if.sh_sel); end
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    rst               = 1'b1;
    bus_if.slice_tick = 1'b0;
    bus_if.home       = 1'b0;
    bus_if.ctrl_dirty = 1'b0;
    bus_if.rd_ack     = 1'b0;
    bus_if.sh_busy    = 1'b0;
    bus_if.sh_done    = 1'b0;
    test_reset();
    test_fetch();
    test_refresh();
    test_overrun();
    test_dirty();
    test_watchdog();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_latch_scheduler.md
LED_LATCH_SCHEDULER -- requirements
Module: led_latch_scheduler

Interface
REQ-001 The block SHALL have these parameters: SLICES, default 360, encoder slices per revolution; CTRL_REFRESH, default 64, grayscale writes between forced control-latch rewrites; WDOG_CYCLES, default 2048, shifter completion timeout.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK_10M, in, 1: the single clock.
- RESET, in, 1: asynchronous active-high reset.
- slice_tick, in, 1: one-cycle pulse per encoder slice (ENC_360).
- home, in, 1: one-cycle pulse at absolute home (ENC_ABS_HOME).
- ctrl_dirty, in, 1: pulse meaning control settings changed.
- rd_req, out, 1: request grayscale data for fetch_idx.
- rd_ack, in, 1: the requested slice data is staged in the shifter.
- fetch_idx, out, 9: slice index being fetched.
- sh_start, out, 1: one-cycle start pulse to the 769-bit shifter.
- sh_sel, out, 1: latch-select bit; 1 = control, 0 = grayscale.
- sh_busy, in, 1: shifter active.
- sh_done, in, 1: one-cycle pulse after LAT is issued.
- overrun_cnt, out, 16: dropped-tick count, saturating.
- fault, out, 1: sticky watchdog fault.
- state_dbg, out, 3: current state encoding.

Function
REQ-003 States: CTRL_LOAD, CTRL_WAIT, ARMED, FETCH, GS_LOAD, GS_WAIT.
REQ-004 Slice position SHALL increment on every slice_tick in every state, wrapping from SLICES-1 to 0.
REQ-005 home SHALL set the slice position to 0 and SHALL win over a simultaneous slice_tick.
REQ-006 In CTRL_LOAD, when sh_busy=0, the block SHALL pulse sh_start with sh_sel=1 for one cycle, then go to CTRL_WAIT. While sh_busy=1 it SHALL hold with no pulse.
REQ-007 In CTRL_WAIT, sh_done SHALL clear the control-pending flag and the grayscale counter, then go to ARMED.
REQ-008 In ARMED, a slice_tick with control pending SHALL go to CTRL_LOAD. Control is pending when ctrl_dirty was seen or the grayscale counter equals CTRL_REFRESH.
REQ-009 In ARMED, a slice_tick with no control pending SHALL capture the post-increment position into fetch_idx and go to FETCH.
REQ-010 In FETCH, rd_req SHALL be held at 1 until the cycle rd_ack=1, then go to GS_LOAD. rd_ack while rd_req=0 SHALL be ignored.
REQ-011 In GS_LOAD, the block SHALL follow the REQ-006 start rule with sh_sel=0, then go to GS_WAIT.
REQ-012 In GS_WAIT, sh_done SHALL increment the grayscale counter (saturating at CTRL_REFRESH) and go to ARMED.
REQ-013 A slice_tick arriving in any state other than ARMED SHALL be dropped and SHALL increment overrun_cnt, saturating at 16'hFFFF.
REQ-014 sh_sel SHALL be stable from the sh_start cycle until sh_done.
REQ-015 ctrl_dirty SHALL set control-pending in any state. A ctrl_dirty coinciding with the sh_done of a control write SHALL remain pending.
REQ-016 Latency from slice_tick in ARMED to sh_start SHALL be 3 cycles when rd_ack and sh_busy are already asserted and deasserted respectively.

Reset
REQ-017 RESET SHALL asynchronously force the following:
- state CTRL_LOAD, so the control latch is written first after reset;
- slice position, fetch_idx, grayscale counter and overrun_cnt to 0;
- rd_req, sh_start, sh_sel and fault to 0;
- control-pending to 1.
REQ-018 RESET asserted mid-shift SHALL abandon the transfer. The first action after release SHALL be a control write.

Configuration
REQ-019 With LED_SCHED_WATCHDOG_EN defined: a WDOG_CYCLES-cycle counter SHALL run in CTRL_WAIT and GS_WAIT. On expiry without sh_done the block SHALL set fault, set control-pending and go to CTRL_LOAD. fault clears only on RESET.
REQ-020 Without LED_SCHED_WATCHDOG_EN: the wait states SHALL wait indefinitely, fault SHALL be constant 0, and no watchdog counter SHALL exist.

Structure
REQ-021 Package led_sched_pkg SHALL hold the following:
- the state enum;
- LATCH_SIZE = 769;
- SEL_CTRL = 1 and SEL_GS = 0;
- the slice-index width of 9.
REQ-022 The slice position counter, with its wrap and home logic, SHALL be the sub-module led_slice_counter. Everything else SHALL be flat.

Verification
REQ-023 Release RESET with sh_busy=0. Required: sh_start with sh_sel=1 on the first edge out of reset; after sh_done, state_dbg = ARMED.
REQ-024 In ARMED, tick with rd_ack returned the next cycle and sh_busy=0. Required: fetch_idx=1, then sh_start with sh_sel=0 exactly 3 cycles after the tick.
REQ-025 Apply 64 grayscale completions, then a tick. Required: a control write (sh_sel=1) instead of a fetch; the counter then restarts.
REQ-026 Send 3 ticks during GS_WAIT. Required: overrun_cnt=3 and slice position advanced by 3. Also: tick at position 359 gives 0; home coinciding with a tick gives 0.
REQ-027 Hold sh_done low for 2048 cycles in GS_WAIT with LED_SCHED_WATCHDOG_EN defined. Required: fault=1 and state CTRL_LOAD. Without the macro: the block is still in GS_WAIT after 10000 cycles with fault=0.
REQ-028 Pulse ctrl_dirty in the same cycle as the control-write sh_done. Required: the next tick triggers another control write.
